// File: rtl/dm_sba_arbiter.sv
// Round-robin arbiter sharing one req/gnt/r_valid bus master between NrPorts requesters.
// Latency: request, grant and response paths are combinational; state updates on the next edge.
// Backpressure: the bus request is held off while MaxOutstanding transactions are in flight.

module dm_sba_fifo #(
   parameter int unsigned Width = 1,
   parameter int unsigned Depth = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_vld,
   input  logic [Width-1:0] wr_dat,
   output logic             full,
   input  logic             rd_rdy,
   output logic             rd_vld,
   output logic [Width-1:0] rd_dat
);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem [Depth];
   logic [PtrW-1:0]  wr_ptr, rd_ptr;
   logic [CntW-1:0]  cnt;
   logic             push, pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full   = (cnt == CntW'(Depth));
   assign rd_vld = (cnt != '0);
   assign rd_dat = mem[rd_ptr];
   assign push   = wr_vld & ~full;
   assign pop    = rd_rdy & rd_vld;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         cnt <= cnt + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= wr_dat;
   end
endmodule

module dm_sba_arbiter #(
   parameter int unsigned NrPorts        = 2,
   parameter int unsigned BusWidth       = 32,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic [NrPorts-1:0]                    req_i,
   input  logic [NrPorts-1:0]                    we_i,
   input  logic [NrPorts-1:0][BusWidth-1:0]      addr_i,
   input  logic [NrPorts-1:0][BusWidth-1:0]      wdata_i,
   input  logic [NrPorts-1:0][BusWidth/8-1:0]    be_i,
   output logic [NrPorts-1:0]                    gnt_o,
   output logic [NrPorts-1:0]                    r_valid_o,
   output logic [BusWidth-1:0]                   r_rdata_o,
   output logic                                  master_req_o,
   output logic [BusWidth-1:0]                   master_add_o,
   output logic                                  master_we_o,
   output logic [BusWidth-1:0]                   master_wdata_o,
   output logic [BusWidth/8-1:0]                 master_be_o,
   input  logic                                  master_gnt_i,
   input  logic                                  master_r_valid_i,
   input  logic [BusWidth-1:0]                   master_r_rdata_i,
   output logic                                  unexpected_rsp_o
);
   localparam int unsigned IdxW = $clog2(NrPorts);
   localparam int unsigned BeW  = BusWidth / 8;

   typedef struct packed {
      logic                we;
      logic [BusWidth-1:0] addr;
      logic [BusWidth-1:0] wdata;
      logic [BeW-1:0]      be;
   } bus_req_t;

   logic [IdxW-1:0] rr_ptr, rr_ptr_d, lock_idx, lock_idx_d;
   logic [IdxW-1:0] arb_idx, sel, head_idx;
   logic            locked, locked_d;
   logic            fifo_full, fifo_vld, issue, grant, rsp_pop;
   bus_req_t        sel_req;

   // Circular search starting at the highest-priority port.
   always_comb begin
      int unsigned j;
      logic        found;
      arb_idx = rr_ptr;
      found   = 1'b0;
      j       = 0;
      for (int unsigned i = 0; i < NrPorts; i++) begin
         j = int'(rr_ptr) + i;
         if (j >= NrPorts) j = j - NrPorts;
         if (!found && req_i[j]) begin
            found   = 1'b1;
            arb_idx = IdxW'(j);
         end
      end
   end

   // A presented-but-ungranted request keeps the mux pinned until the bus accepts it.
   always_comb begin
      sel = arb_idx;
      if (!rst_ni)                      sel = '0;
      else if (locked && req_i[lock_idx]) sel = lock_idx;
   end

   assign issue   = rst_ni & (|req_i) & ~fifo_full;
   assign grant   = issue & master_gnt_i;
   assign rsp_pop = rst_ni & master_r_valid_i & fifo_vld;

   assign sel_req = '{we: we_i[sel], addr: addr_i[sel], wdata: wdata_i[sel], be: be_i[sel]};

   assign master_req_o     = issue;
   assign master_add_o     = sel_req.addr;
   assign master_we_o      = sel_req.we;
   assign master_wdata_o   = sel_req.wdata;
   assign master_be_o      = sel_req.be;
   assign r_rdata_o        = rst_ni ? master_r_rdata_i : '0;
   assign unexpected_rsp_o = rst_ni & master_r_valid_i & ~fifo_vld;

   always_comb begin
      gnt_o     = '0;
      r_valid_o = '0;
      if (grant)   gnt_o[sel]          = 1'b1;
      if (rsp_pop) r_valid_o[head_idx] = 1'b1;
   end

   always_comb begin
      rr_ptr_d   = rr_ptr;
      locked_d   = locked;
      lock_idx_d = lock_idx;
      if (grant) begin
         rr_ptr_d = (sel == IdxW'(NrPorts - 1)) ? '0 : sel + 1'b1;
         locked_d = 1'b0;
      end else if (issue) begin
         locked_d   = 1'b1;
         lock_idx_d = sel;
      end else if (locked && !req_i[lock_idx]) begin
         locked_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr   <= '0;
         locked   <= 1'b0;
         lock_idx <= '0;
      end else begin
         rr_ptr   <= rr_ptr_d;
         locked   <= locked_d;
         lock_idx <= lock_idx_d;
      end
   end

   // In-order record of which port owns each outstanding transaction.
   dm_sba_fifo #(
      .Width (IdxW),
      .Depth (MaxOutstanding)
   ) u_id_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .wr_vld (grant),
      .wr_dat (sel),
      .full   (fifo_full),
      .rd_rdy (rsp_pop),
      .rd_vld (fifo_vld),
      .rd_dat (head_idx)
   );
endmodule
